// File: rtl/noc_tg_pkg.sv
// noc_tg_pkg: shared definitions for the NoC traffic node.
//   - flit type encodings and field positions
//   - destination-pattern enum (cfg_mode) and generator FSM state enum
//   - LFSR step function used for uniform-random destinations
package noc_tg_pkg;

  // Flit type field encodings (bits [1:0])
  localparam logic [1:0] FT_DATA = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_HT   = 2'b11;

  // Field positions
  localparam int TYPE_LSB = 0;
  localparam int TYPE_MSB = 1;
  localparam int DST_LSB  = 4;
  localparam int DST_MSB  = 11;
  localparam int SRC_LSB  = 12;
  localparam int SRC_MSB  = 19;
  localparam int VCH_LSB  = 20;
  localparam int VCH_MSB  = 23;
  localparam int FID_LSB  = 4;
  localparam int FID_MSB  = 11;
  localparam int TS_LSB   = 16;
  localparam int TS_MSB   = 31;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RAND  = 2'd1,
    MODE_BITC  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_HEAD = 3'd2,
    ST_BODY = 3'd3,
    ST_END  = 3'd4
  } state_e;

  // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (right-shifting form)
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/noc_tg_sink.sv
// noc_tg_sink: receive side of the traffic node.
//   Counts ejected flits/packets, checks per-VC packet framing and head
//   destination, and (with NOC_TG_LATENCY_EN defined) accumulates tail latency.
// Ports:
//   clk, rst_          clock, async active-low reset
//   odata/ovalid/ovch  ejected flit from the router local output
//   now                free-running 16-bit cycle counter from the generator
//   recv_flits/recv_pkts/err_cnt  statistics
//   lat_sum/lat_max    latency statistics (0 when NOC_TG_LATENCY_EN undefined)
module noc_tg_sink
  import noc_tg_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int VCH_NUM = 2,
  parameter int DATAW   = 63,
  parameter int CNTW    = 32,
  parameter int VCW     = 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   odata,
  input  logic             ovalid,
  input  logic [VCW-1:0]   ovch,
  input  logic [15:0]      now,
  output logic [CNTW-1:0]  recv_flits,
  output logic [CNTW-1:0]  recv_pkts,
  output logic [CNTW-1:0]  err_cnt,
  output logic [CNTW-1:0]  lat_sum,
  output logic [15:0]      lat_max
);

  localparam logic [7:0] NODE_ID8 = 8'(NODE_ID);

  logic [CNTW-1:0]    r_recv_flits;
  logic [CNTW-1:0]    r_recv_pkts;
  logic [CNTW-1:0]    r_err_cnt;
  logic [VCH_NUM-1:0] r_in_pkt;

  logic [1:0] w_type;
  logic       w_is_head;
  logic       w_is_tail;
  logic       w_in_pkt;
  logic       w_err;

  // Classify the incoming flit and decide whether it is a protocol error
  always_comb begin
    w_type    = odata[TYPE_MSB:TYPE_LSB];
    w_is_head = w_type[0];
    w_is_tail = w_type[1];
    w_in_pkt  = r_in_pkt[ovch];
    // A single flit can raise at most one error even if several checks trip
    if (w_is_head) begin
      w_err = w_in_pkt || (odata[DST_MSB:DST_LSB] != NODE_ID8);
    end else begin
      w_err = !w_in_pkt;
    end
  end

  // Statistics counters and per-VC in-packet tracking
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_recv_flits <= '0;
      r_recv_pkts  <= '0;
      r_err_cnt    <= '0;
      r_in_pkt     <= '0;
    end else if (ovalid) begin
      r_recv_flits <= r_recv_flits + CNTW'(1);
      if (w_is_tail) r_recv_pkts <= r_recv_pkts + CNTW'(1);
      if (w_err)     r_err_cnt   <= r_err_cnt + CNTW'(1);
      if (w_is_head && !w_is_tail) begin
        r_in_pkt[ovch] <= 1'b1;
      end else if (w_is_tail) begin
        r_in_pkt[ovch] <= 1'b0;
      end
    end
  end

  assign recv_flits = r_recv_flits;
  assign recv_pkts  = r_recv_pkts;
  assign err_cnt    = r_err_cnt;

`ifdef NOC_TG_LATENCY_EN
  logic [CNTW-1:0] r_lat_sum;
  logic [15:0]     r_lat_max;
  logic [15:0]     w_lat;

  // Modulo-2^16 difference handles wrap of the cycle counter
  assign w_lat = now - odata[TS_MSB:TS_LSB];

  // Latency accumulation on plain tail flits (headtail packets carry no stamp)
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_lat_sum <= '0;
      r_lat_max <= '0;
    end else if (ovalid && (w_type == FT_TAIL)) begin
      r_lat_sum <= r_lat_sum + CNTW'(w_lat);
      if (w_lat > r_lat_max) r_lat_max <= w_lat;
    end
  end

  assign lat_sum = r_lat_sum;
  assign lat_max = r_lat_max;
`else
  assign lat_sum = '0;
  assign lat_max = 16'd0;
`endif

endmodule

// File: rtl/noc_traffic_node.sv
// noc_traffic_node: per-node NoC traffic generator and sink.
//   Generator builds wormhole packets (head/data/tail or headtail) with a
//   selectable destination pattern, round-robin VC choice, packet-level
//   per-VC flow control and a programmable gap. The sink (noc_tg_sink)
//   checks and counts ejected traffic.
//   Optional macro: NOC_TG_LATENCY_EN enables lat_sum/lat_max.
// Ports:
//   clk, rst_                       clock, async active-low reset
//   cfg_en/mode/dst/len/gap/pkt_limit  generator configuration
//   idata/ivalid/ivch, ordy         to/from router local input
//   odata/ovalid/ovch               from router local output
//   sent_*/recv_*/err_cnt/done      statistics
//   lat_sum/lat_max                 latency statistics
module noc_traffic_node
  import noc_tg_pkg::*;
#(
  parameter int NODE_ID  = 0,
  parameter int NODE_NUM = 16,
  parameter int VCH_NUM  = 2,
  parameter int DATAW    = 63,
  parameter int CNTW     = 32,
  localparam int VCW     = (VCH_NUM > 1) ? $clog2(VCH_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               cfg_en,
  input  logic [1:0]         cfg_mode,
  input  logic [7:0]         cfg_dst,
  input  logic [7:0]         cfg_len,
  input  logic [7:0]         cfg_gap,
  input  logic [CNTW-1:0]    cfg_pkt_limit,
  output logic [DATAW:0]     idata,
  output logic               ivalid,
  output logic [VCW-1:0]     ivch,
  input  logic [VCH_NUM-1:0] ordy,
  input  logic [DATAW:0]     odata,
  input  logic               ovalid,
  input  logic [VCW-1:0]     ovch,
  output logic [CNTW-1:0]    sent_flits,
  output logic [CNTW-1:0]    sent_pkts,
  output logic [CNTW-1:0]    recv_flits,
  output logic [CNTW-1:0]    recv_pkts,
  output logic [CNTW-1:0]    err_cnt,
  output logic               done,
  output logic [CNTW-1:0]    lat_sum,
  output logic [15:0]        lat_max
);

  localparam logic [7:0]     NODE_ID8  = 8'(NODE_ID);
  localparam logic [7:0]     NODE_MASK = 8'(NODE_NUM - 1);
  localparam logic [VCW-1:0] VCH_LAST  = VCW'(VCH_NUM - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [7:0]      r_gap;
  logic [7:0]      r_len;
  logic [7:0]      r_fid;
  logic [7:0]      r_dst;
  logic [VCW-1:0]  r_vch;
  logic [VCW-1:0]  r_vc_ptr;
  logic [15:0]     r_ts;
  logic [15:0]     r_now;
  logic [15:0]     r_lfsr;
  logic [CNTW-1:0] r_sent_flits;
  logic [CNTW-1:0] r_sent_pkts;
  logic            r_done;

  logic            w_ivalid;
  logic            w_head_fire;
  logic            w_head_entry;
  logic            w_load_gap;
  logic [7:0]      w_len_eff;
  logic [7:0]      w_rand;
  logic [7:0]      w_dst_new;
  logic [CNTW-1:0] w_pkts_inc;
  logic            w_limit_hit;
  logic [DATAW:0]  w_idata;

  assign w_len_eff   = (cfg_len == 8'd0) ? 8'd1 : cfg_len;
  assign w_rand      = r_lfsr[7:0] & NODE_MASK;
  assign w_pkts_inc  = r_sent_pkts + CNTW'(1);
  assign w_limit_hit = (cfg_pkt_limit != '0) && (w_pkts_inc == cfg_pkt_limit);

  // Destination for the packet about to start
  always_comb begin
    case (mode_e'(cfg_mode))
      MODE_RAND: begin
        // Never target ourselves: bump to the next node
        w_dst_new = (w_rand == NODE_ID8) ? ((NODE_ID8 + 8'd1) & NODE_MASK) : w_rand;
      end
      MODE_BITC: w_dst_new = ~NODE_ID8 & NODE_MASK;
      default:   w_dst_new = cfg_dst;
    endcase
  end

  // Next-state and flit-valid decode; gap of 0 skips GAP entirely
  always_comb begin
    w_state_nxt = r_state;
    w_ivalid    = 1'b0;
    w_head_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_en && !r_done) begin
          w_state_nxt = (cfg_gap == 8'd0) ? ST_HEAD : ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!cfg_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap == 8'd1) begin
          w_state_nxt = ST_HEAD;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_HEAD: begin
        if (!cfg_en) begin
          w_state_nxt = ST_IDLE;
        end else if (ordy[r_vch]) begin
          // Whole packet is committed once the head goes out
          w_ivalid    = 1'b1;
          w_head_fire = 1'b1;
          w_state_nxt = (r_len == 8'd1) ? ST_END : ST_BODY;
        end else begin
          w_state_nxt = ST_HEAD;
        end
      end
      ST_BODY: begin
        w_ivalid    = 1'b1;
        w_state_nxt = (r_fid == r_len - 8'd1) ? ST_END : ST_BODY;
      end
      ST_END: begin
        if (w_limit_hit) begin
          w_state_nxt = ST_IDLE;
        end else if (cfg_en) begin
          w_state_nxt = (cfg_gap == 8'd0) ? ST_HEAD : ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_head_entry = (w_state_nxt == ST_HEAD) && (r_state != ST_HEAD);
  assign w_load_gap   = (w_state_nxt == ST_GAP) && (r_state != ST_GAP);

  // Flit assembly from the latched packet context
  always_comb begin
    w_idata = '0;
    if (w_ivalid && (r_state == ST_HEAD)) begin
      w_idata[TYPE_MSB:TYPE_LSB] = (r_len == 8'd1) ? FT_HT : FT_HEAD;
      w_idata[DST_MSB:DST_LSB]   = r_dst;
      w_idata[SRC_MSB:SRC_LSB]   = NODE_ID8;
      w_idata[VCH_MSB:VCH_LSB]   = 4'(r_vch);
    end else if (w_ivalid) begin
      w_idata[TYPE_MSB:TYPE_LSB] = (r_fid == r_len - 8'd1) ? FT_TAIL : FT_DATA;
      w_idata[FID_MSB:FID_LSB]   = r_fid;
      w_idata[TS_MSB:TS_LSB]     = r_ts;
    end else begin
      w_idata = '0;
    end
  end

  // FSM state, cycle counter and gap counter
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_now   <= 16'd0;
      r_gap   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_now   <= r_now + 16'd1;
      if (w_load_gap) begin
        r_gap <= cfg_gap;
      end else if (r_state == ST_GAP) begin
        r_gap <= r_gap - 8'd1;
      end
    end
  end

  // Packet context latched on HEAD entry; LFSR steps once per packet
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_vch  <= '0;
      r_dst  <= 8'd0;
      r_len  <= 8'd1;
      r_lfsr <= LFSR_SEED ^ 16'(NODE_ID);
    end else if (w_head_entry) begin
      r_vch  <= r_vc_ptr;
      r_dst  <= w_dst_new;
      r_len  <= w_len_eff;
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Body flit id and enqueue timestamp (taken when the head actually leaves)
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_fid <= 8'd0;
      r_ts  <= 16'd0;
    end else if (w_head_fire) begin
      r_fid <= 8'd1;
      r_ts  <= r_now;
    end else if (r_state == ST_BODY) begin
      r_fid <= r_fid + 8'd1;
    end
  end

  // Send statistics, VC round-robin pointer and sticky done
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sent_flits <= '0;
      r_sent_pkts  <= '0;
      r_vc_ptr     <= '0;
      r_done       <= 1'b0;
    end else begin
      if (w_ivalid) r_sent_flits <= r_sent_flits + CNTW'(1);
      if (r_state == ST_END) begin
        r_sent_pkts <= w_pkts_inc;
        r_vc_ptr    <= (r_vc_ptr == VCH_LAST) ? '0 : r_vc_ptr + VCW'(1);
        if (w_limit_hit) r_done <= 1'b1;
      end
    end
  end

  assign idata      = w_idata;
  assign ivalid     = w_ivalid;
  assign ivch       = w_ivalid ? r_vch : '0;
  assign sent_flits = r_sent_flits;
  assign sent_pkts  = r_sent_pkts;
  assign done       = r_done;

  noc_tg_sink #(
    .NODE_ID (NODE_ID),
    .VCH_NUM (VCH_NUM),
    .DATAW   (DATAW),
    .CNTW    (CNTW),
    .VCW     (VCW)
  ) u_sink (
    .clk        (clk),
    .rst_       (rst_),
    .odata      (odata),
    .ovalid     (ovalid),
    .ovch       (ovch),
    .now        (r_now),
    .recv_flits (recv_flits),
    .recv_pkts  (recv_pkts),
    .err_cnt    (err_cnt),
    .lat_sum    (lat_sum),
    .lat_max    (lat_max)
  );

endmodule

// File: tb/tb_noc_traffic_node.sv
// Directed self-checking bench for noc_traffic_node (NODE_ID = 5, 16 nodes, 2 VCs).
module tb_noc_traffic_node;

  logic        clk = 1'b0;
  logic        rst_;
  logic        cfg_en;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_dst;
  logic [7:0]  cfg_len;
  logic [7:0]  cfg_gap;
  logic [31:0] cfg_pkt_limit;
  logic [63:0] idata;
  logic        ivalid;
  logic [0:0]  ivch;
  logic [1:0]  ordy;
  logic [63:0] odata;
  logic        ovalid;
  logic [0:0]  ovch;
  logic [31:0] sent_flits, sent_pkts, recv_flits, recv_pkts, err_cnt, lat_sum;
  logic        done;
  logic [15:0] lat_max;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] tb_now;

  always #5 clk = ~clk;

  // Reference free-running cycle counter
  always @(posedge clk or negedge rst_) begin
    if (!rst_) tb_now <= 16'd0;
    else       tb_now <= tb_now + 16'd1;
  end

  noc_traffic_node #(
    .NODE_ID(5), .NODE_NUM(16), .VCH_NUM(2), .DATAW(63), .CNTW(32)
  ) dut (
    .clk(clk), .rst_(rst_), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_pkt_limit(cfg_pkt_limit),
    .idata(idata), .ivalid(ivalid), .ivch(ivch), .ordy(ordy),
    .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .sent_flits(sent_flits), .sent_pkts(sent_pkts), .recv_flits(recv_flits),
    .recv_pkts(recv_pkts), .err_cnt(err_cnt), .done(done),
    .lat_sum(lat_sum), .lat_max(lat_max)
  );

  function automatic logic [63:0] mk_head(input logic [1:0] t, input logic [7:0] dst, input logic [3:0] v);
    logic [63:0] f;
    f = 64'd0;
    f[1:0] = t; f[11:4] = dst; f[19:12] = 8'd3; f[23:20] = v;
    return f;
  endfunction

  function automatic logic [63:0] mk_body(input logic [1:0] t, input logic [7:0] fid, input logic [15:0] ts);
    logic [63:0] f;
    f = 64'd0;
    f[1:0] = t; f[11:4] = fid; f[31:16] = ts;
    return f;
  endfunction

  task automatic do_reset();
    rst_ = 1'b0;
    cfg_en = 1'b0; cfg_mode = 2'd0; cfg_dst = 8'd0; cfg_len = 8'd1; cfg_gap = 8'd0;
    cfg_pkt_limit = 32'd0; ordy = 2'b11; odata = 64'd0; ovalid = 1'b0; ovch = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic send_flit(input logic v, input logic [63:0] f);
    @(negedge clk);
    ovalid = 1'b1; ovch = v; odata = f;
    @(negedge clk);
    ovalid = 1'b0; odata = 64'd0;
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    cfg_en = 1'b0; cfg_mode = 2'd0; cfg_dst = 8'd0; cfg_len = 8'd1; cfg_gap = 8'd0;
    cfg_pkt_limit = 32'd0; ordy = 2'b11; odata = 64'd0; ovalid = 1'b0; ovch = 1'b0;
    #2 rst_ = 1'b0;
    #1;
    n_checks++;
    if ({ivalid, done} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b expected 00", {ivalid, done}); end
    n_checks++;
    if (idata !== 64'd0) begin n_errors++; $display("FAIL reset_idata: got %h expected 0", idata); end
    n_checks++;
    if ({sent_flits, sent_pkts, recv_flits, recv_pkts, err_cnt} !== 160'd0) begin
      n_errors++; $display("FAIL reset_counters: got %h expected 0", {sent_flits, sent_pkts, recv_flits, recv_pkts, err_cnt});
    end
    n_checks++;
    if ({lat_sum, lat_max} !== 48'd0) begin n_errors++; $display("FAIL reset_latency: got %h expected 0", {lat_sum, lat_max}); end
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_fixed_packet();
    logic [63:0] fl [8];
    int          cyc [8];
    int          n;
    logic [15:0] head_now;
    do_reset();
    cfg_mode = 2'd0; cfg_dst = 8'd4; cfg_len = 8'd5; cfg_gap = 8'd0; cfg_pkt_limit = 32'd1; cfg_en = 1'b1;
    n = 0; head_now = 16'd0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (ivalid === 1'b1) begin
        if (n == 0) head_now = tb_now;
        if (n < 8) begin fl[n] = idata; cyc[n] = c; end
        n++;
      end
    end
    n_checks++;
    if (n != 5) begin n_errors++; $display("FAIL fixed_nflits: got %0d expected 5", n); end
    if (n == 5) begin
      n_checks++;
      if (fl[0][23:0] !== 24'h005041) begin n_errors++; $display("FAIL fixed_head: got %h expected 005041", fl[0][23:0]); end
      for (int i = 1; i < 5; i++) begin
        n_checks++;
        if (fl[i][11:0] !== {i[7:0], 2'b00, ((i == 4) ? 2'b10 : 2'b00)} || fl[i][31:16] !== head_now || cyc[i] != cyc[0] + i) begin
          n_errors++;
          $display("FAIL fixed_body%0d: got flit %h cycle %0d expected id %0d ts %h cycle %0d", i, fl[i], cyc[i], i, head_now, cyc[0] + i);
        end
      end
    end
    n_checks++;
    if ({sent_flits, sent_pkts, done} !== {32'd5, 32'd1, 1'b1}) begin
      n_errors++; $display("FAIL fixed_stats: got flits %0d pkts %0d done %b expected 5 1 1", sent_flits, sent_pkts, done);
    end
    cfg_en = 1'b0;
  endtask

  task automatic test_ordy_wait();
    int bad;
    do_reset();
    cfg_len = 8'd1; cfg_gap = 8'd0; cfg_pkt_limit = 32'd1; cfg_dst = 8'd2; ordy = 2'b10; cfg_en = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); ordy = 2'b10; #1;
      if (ivalid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL ordy_wait_idle: got %0d valid cycles expected 0", bad); end
    @(negedge clk); ordy = 2'b11; #1;
    n_checks++;
    if ({ivalid, ivch, idata[1:0]} !== 4'b1011) begin
      n_errors++; $display("FAIL ordy_head_on_rise: got valid %b vch %b type %b expected 1 0 11", ivalid, ivch, idata[1:0]);
    end
    @(negedge clk); #1;
    n_checks++;
    if (ivalid !== 1'b0) begin n_errors++; $display("FAIL ordy_after_headtail: got %b expected 0", ivalid); end
  endtask

  task automatic test_vc_rr();
    logic [0:0] vs [8];
    int         cyc [8];
    int         n;
    do_reset();
    cfg_len = 8'd1; cfg_gap = 8'd2; cfg_pkt_limit = 32'd4; cfg_dst = 8'd9; cfg_en = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (ivalid === 1'b1) begin
        if (n < 8) begin vs[n] = ivch; cyc[n] = c; end
        n++;
        n_checks++;
        if (idata[1:0] !== 2'b11) begin n_errors++; $display("FAIL rr_type: got %b expected 11", idata[1:0]); end
      end
    end
    n_checks++;
    if (n != 4) begin n_errors++; $display("FAIL rr_count: got %0d expected 4", n); end
    if (n == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (vs[i] !== i[0:0]) begin n_errors++; $display("FAIL rr_vch%0d: got %0d expected %0d", i, vs[i], i % 2); end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (cyc[i] - cyc[i-1] != 4) begin n_errors++; $display("FAIL rr_spacing%0d: got %0d expected 4", i, cyc[i] - cyc[i-1]); end
      end
    end
    n_checks++;
    if ({sent_pkts, done} !== {32'd4, 1'b1}) begin n_errors++; $display("FAIL rr_stats: got pkts %0d done %b expected 4 1", sent_pkts, done); end
  endtask

  task automatic test_dest_patterns();
    int heads;
    int bad;
    // bit-complement of node 5 in a 16-node mesh
    do_reset();
    cfg_mode = 2'd2; cfg_dst = 8'd1; cfg_len = 8'd2; cfg_pkt_limit = 32'd3; cfg_en = 1'b1;
    heads = 0; bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (ivalid === 1'b1 && idata[0] === 1'b1) begin
        heads++;
        if (idata[11:4] !== 8'd10) bad++;
      end
    end
    n_checks++;
    if (heads != 3 || bad != 0) begin n_errors++; $display("FAIL bitcomp_dst: got %0d heads %0d wrong expected 3 heads dst 10", heads, bad); end
    // reserved mode behaves as fixed
    do_reset();
    cfg_mode = 2'd3; cfg_dst = 8'd7; cfg_len = 8'd1; cfg_pkt_limit = 32'd2; cfg_en = 1'b1;
    heads = 0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (ivalid === 1'b1) begin
        heads++;
        if (idata[11:4] !== 8'd7) bad++;
      end
    end
    n_checks++;
    if (heads != 2 || bad != 0) begin n_errors++; $display("FAIL reserved_mode_dst: got %0d heads %0d wrong expected 2 heads dst 7", heads, bad); end
  endtask

  task automatic test_random_dst();
    int          heads;
    int          bad;
    logic [15:0] seen;
    do_reset();
    cfg_mode = 2'd1; cfg_len = 8'd1; cfg_gap = 8'd0; cfg_pkt_limit = 32'd1000; cfg_en = 1'b1;
    heads = 0; bad = 0; seen = 16'd0;
    for (int c = 0; c < 2100 && heads < 1000; c++) begin
      @(negedge clk); #1;
      if (ivalid === 1'b1) begin
        heads++;
        if (idata[11:4] == 8'd5 || idata[11:4] > 8'd15) bad++;
        else seen[idata[7:4]] = 1'b1;
      end
    end
    n_checks++;
    if (heads != 1000) begin n_errors++; $display("FAIL random_count: got %0d expected 1000", heads); end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL random_dst_self: got %0d bad dsts expected 0", bad); end
    n_checks++;
    if ($countones(seen) < 8) begin n_errors++; $display("FAIL random_spread: got %0d distinct dsts expected at least 8", $countones(seen)); end
  endtask

  task automatic test_sink();
    do_reset();
    send_flit(1'b0, mk_body(2'b00, 8'd1, 16'd0));
    send_flit(1'b0, mk_head(2'b01, 8'd3, 4'd0));
    n_checks++;
    if ({err_cnt, recv_flits} !== {32'd2, 32'd2}) begin n_errors++; $display("FAIL sink_bad_flits: got err %0d flits %0d expected 2 2", err_cnt, recv_flits); end
    send_flit(1'b1, mk_head(2'b01, 8'd5, 4'd1));
    send_flit(1'b1, mk_body(2'b00, 8'd1, 16'd0));
    send_flit(1'b1, mk_body(2'b10, 8'd2, 16'd0));
    n_checks++;
    if ({err_cnt, recv_pkts, recv_flits} !== {32'd2, 32'd1, 32'd5}) begin
      n_errors++; $display("FAIL sink_legal_pkt: got err %0d pkts %0d flits %0d expected 2 1 5", err_cnt, recv_pkts, recv_flits);
    end
    // in-packet head with wrong dst counts only once
    send_flit(1'b0, mk_head(2'b01, 8'd3, 4'd0));
    n_checks++;
    if (err_cnt !== 32'd3) begin n_errors++; $display("FAIL sink_single_err: got %0d expected 3", err_cnt); end
    send_flit(1'b0, mk_body(2'b10, 8'd1, 16'd0));
    send_flit(1'b1, mk_head(2'b11, 8'd5, 4'd1));
    n_checks++;
    if ({err_cnt, recv_pkts, recv_flits} !== {32'd3, 32'd3, 32'd8}) begin
      n_errors++; $display("FAIL sink_tail_headtail: got err %0d pkts %0d flits %0d expected 3 3 8", err_cnt, recv_pkts, recv_flits);
    end
  endtask

  task automatic test_reset_mid_body();
    int found;
    do_reset();
    cfg_len = 8'd8; cfg_gap = 8'd0; cfg_pkt_limit = 32'd0; cfg_dst = 8'd1; cfg_en = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk); #1;
      if (ivalid === 1'b1 && idata[1:0] === 2'b00) found = 1;
    end
    n_checks++;
    if (found == 0) begin n_errors++; $display("FAIL midbody_reach: got no data flit expected one within 20 cycles"); end
    #2 rst_ = 1'b0;
    #1;
    n_checks++;
    if ({ivalid, sent_flits} !== 33'd0) begin n_errors++; $display("FAIL midbody_async: got valid %b flits %0d expected 0 0", ivalid, sent_flits); end
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    n_checks++;
    if ({sent_flits, sent_pkts, done} !== 65'd0) begin n_errors++; $display("FAIL midbody_cleared: got %0d %0d %b expected 0 0 0", sent_flits, sent_pkts, done); end
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk); #1;
      if (ivalid === 1'b1) begin
        found = 1;
        n_checks++;
        if (idata[1:0] !== 2'b01) begin n_errors++; $display("FAIL midbody_restart_type: got %b expected 01", idata[1:0]); end
      end
    end
    n_checks++;
    if (found == 0) begin n_errors++; $display("FAIL midbody_restart: got no flit expected head within 10 cycles"); end
    cfg_en = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    repeat (25) @(negedge clk);
    send_flit(1'b0, mk_head(2'b01, 8'd5, 4'd0));
    @(negedge clk);
    ovalid = 1'b1; ovch = 1'b0; odata = mk_body(2'b10, 8'd1, tb_now - 16'd20);
    @(negedge clk);
    ovalid = 1'b0;
    send_flit(1'b1, mk_body(2'b11, 8'd5, 16'd0) | mk_head(2'b11, 8'd5, 4'd1));
    #1;
`ifdef NOC_TG_LATENCY_EN
    n_checks++;
    if ({lat_sum, lat_max} !== {32'd20, 16'd20}) begin n_errors++; $display("FAIL latency: got sum %0d max %0d expected 20 20", lat_sum, lat_max); end
`else
    n_checks++;
    if ({lat_sum, lat_max} !== 48'd0) begin n_errors++; $display("FAIL latency_off: got sum %0d max %0d expected 0 0", lat_sum, lat_max); end
`endif
    n_checks++;
    if ({recv_pkts, err_cnt} !== {32'd2, 32'd0}) begin n_errors++; $display("FAIL latency_sink: got pkts %0d err %0d expected 2 0", recv_pkts, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_fixed_packet();
    test_ordy_wait();
    test_vc_rr();
    test_dest_patterns();
    test_random_dst();
    test_sink();
    test_reset_mid_body();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
